// File: rtl/uart_rx_frame.sv
// UART receive framer: synchronises the serial line, detects the start edge, and
// assembles LSB-first data bits on each baud-generator mid-bit pulse.
module uart_rx_frame #(
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rs232_rx,
  input  logic       clk_bps,
  output logic       bps_start,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int unsigned CNT_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_BITS);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t                 state, state_nx;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s, rx_d, fall;
  logic [DATA_BITS-1:0]   shifter, shift_nx;
  logic [CNT_W-1:0]       bit_cnt, cnt_nx;
  logic [7:0]             data_ext, data_nx;
  logic                   valid_nx, err_nx;

  // Synchroniser and edge flops preset to the idle level so reset release never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
      rx_d   <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rs232_rx};
      rx_d   <= rx_s;
    end
  end

  assign rx_s = sync_q[SYNC_STAGES-1];
  assign fall = rx_d & ~rx_s;

  always_comb begin
    data_ext                = '0;
    data_ext[DATA_BITS-1:0] = shifter;
  end

  always_comb begin
    state_nx = state;
    shift_nx = shifter;
    cnt_nx   = bit_cnt;
    data_nx  = rx_data;
    valid_nx = 1'b0;
    err_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (fall) state_nx = START;
      end
      START: begin
        if (clk_bps) begin
          if (rx_s) begin
            state_nx = IDLE;
          end else begin
            state_nx = DATA;
            cnt_nx   = '0;
          end
        end
      end
      DATA: begin
        if (clk_bps) begin
          shift_nx = {rx_s, shifter[DATA_BITS-1:1]};
          if (bit_cnt != CNT_FULL) cnt_nx = bit_cnt + 1'b1;
          if (bit_cnt >= CNT_LAST) state_nx = STOP;
        end
      end
      STOP: begin
        if (clk_bps) begin
          state_nx = IDLE;
          if (rx_s) begin
            valid_nx = 1'b1;
            data_nx  = data_ext;
          end else begin
            err_nx = 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Outputs register from next-state so strobes and bps_start fall land on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shifter   <= '0;
      bit_cnt   <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      bps_start <= 1'b0;
    end else begin
      state     <= state_nx;
      shifter   <= shift_nx;
      bit_cnt   <= cnt_nx;
      rx_data   <= data_nx;
      rx_valid  <= valid_nx;
      frame_err <= err_nx;
      bps_start <= (state_nx != IDLE);
    end
  end

  assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// Randomised bench for uart_rx_frame with a behavioural baud generator (shortened bit
// period) and a queue of expected frame outcomes.
module tb_uart_rx_frame;

  localparam int unsigned BIT  = 32;
  localparam int unsigned SYNC = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       rs232_rx;
  logic       clk_bps;
  logic       bps_start;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       rx_busy;

  logic        gen_pulse = 1'b0;
  logic        force_bps;
  int unsigned bcnt = 0;

  int         n_checks = 0;
  int         n_err    = 0;
  bit         exp_err[$];
  logic [7:0] exp_dat[$];
  logic [7:0] last_good = 8'h00;
  int         hi_cnt = 0;

  always #5 clk = ~clk;

  uart_rx_frame #(.DATA_BITS(8), .SYNC_STAGES(SYNC)) dut (
    .clk       (clk),
    .rst       (rst),
    .rs232_rx  (rs232_rx),
    .clk_bps   (clk_bps),
    .bps_start (bps_start),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .rx_busy   (rx_busy)
  );

  // Baud generator: count held at zero while bps_start is low, pulse at mid-bit.
  always_ff @(posedge clk) begin
    if (!bps_start) begin
      bcnt      <= 0;
      gen_pulse <= 1'b0;
    end else begin
      bcnt      <= (bcnt == BIT - 1) ? 0 : bcnt + 1;
      gen_pulse <= (bcnt == BIT / 2 - 1);
    end
  end
  assign clk_bps = gen_pulse | force_bps;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      if (bps_start) hi_cnt++;
      if (rx_valid || frame_err) begin
        if (exp_err.size() == 0) begin
          check("unexpected_strobe", {30'd0, rx_valid, frame_err}, 32'd0);
        end else begin
          bit         e;
          logic [7:0] d;
          e = exp_err.pop_front();
          d = exp_dat.pop_front();
          check("strobe_kind", {30'd0, rx_valid, frame_err}, e ? 32'd1 : 32'd2);
          check("bps_drop_with_strobe", {31'd0, bps_start}, 32'd0);
          if (!e) last_good = d;
          check("rx_data", {24'd0, rx_data}, {24'd0, last_good});
        end
      end
    end
  end

  task automatic wait_bits(input int unsigned nbits);
    repeat (nbits * BIT) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_ok);
    exp_err.push_back(!stop_ok);
    exp_dat.push_back(d);
    rs232_rx = 1'b0;
    wait_bits(1);
    for (int i = 0; i < 8; i++) begin
      rs232_rx = d[i];
      wait_bits(1);
    end
    rs232_rx = stop_ok;
    wait_bits(1);
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while (exp_err.size() != 0 && t < 4 * BIT) begin
      @(negedge clk);
      t++;
    end
    check(tag, exp_err.size(), 32'd0);
  endtask

  initial begin
    #(90000 * 10);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    rst       = 1'b0;
    rs232_rx  = 1'b1;
    force_bps = 1'b0;
    #1 rst = 1'b1;
    #20;
    check("rst_bps_start", {31'd0, bps_start}, 32'd0);
    check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_rx_busy", {31'd0, rx_busy}, 32'd0);
    check("rst_rx_data", {24'd0, rx_data}, 32'd0);
    @(negedge clk) rst = 1'b0;
    wait_bits(2);
    check("idle_after_release", {31'd0, rx_busy}, 32'd0);

    // Single frame: start latency and bps_start duration
    hi_cnt = 0;
    exp_err.push_back(1'b0);
    exp_dat.push_back(8'h55);
    rs232_rx = 1'b0;
    lat = 0;
    while (!bps_start && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("start_latency_ok", {31'd0, (lat >= SYNC + 1 && lat <= SYNC + 2)}, 32'd1);
    wait_bits(1);
    void'(exp_err.pop_back());
    void'(exp_dat.pop_back());
    for (int i = 0; i < lat; i++) @(negedge clk);
    begin
      logic [7:0] d;
      d = 8'h55;
      exp_err.push_back(1'b0);
      exp_dat.push_back(d);
      for (int i = 0; i < 8; i++) begin
        rs232_rx = d[i];
        wait_bits(1);
      end
      rs232_rx = 1'b1;
      wait_bits(2);
    end
    drain("drain_55");
    check("bps_start_len_ok",
          {31'd0, (hi_cnt >= 9 * BIT + BIT / 2 - 2 && hi_cnt <= 9 * BIT + BIT / 2 + 3)}, 32'd1);
    check("bps_low_after_55", {31'd0, bps_start}, 32'd0);

    // Back-to-back frames with no idle gap
    send_frame(8'hA3, 1'b1);
    send_frame(8'h0F, 1'b1);
    rs232_rx = 1'b1;
    wait_bits(1);
    drain("drain_b2b");

    // Short low glitch: false start, no strobe
    hi_cnt = 0;
    rs232_rx = 1'b0;
    repeat (BIT / 4) @(negedge clk);
    rs232_rx = 1'b1;
    wait_bits(2);
    check("glitch_bps_len_ok", {31'd0, (hi_cnt >= BIT / 2 - 1 && hi_cnt <= BIT / 2 + 3)}, 32'd1);
    check("glitch_idle", {31'd0, rx_busy}, 32'd0);

    // Framing error followed by a break, then recovery
    send_frame(8'hFF, 1'b0);
    wait_bits(30);
    drain("drain_ferr");
    check("break_no_busy", {31'd0, rx_busy}, 32'd0);
    check("break_no_bps", {31'd0, bps_start}, 32'd0);
    rs232_rx = 1'b1;
    wait_bits(2);
    send_frame(8'h81, 1'b1);
    rs232_rx = 1'b1;
    wait_bits(1);
    drain("drain_81");

    // Forced clk_bps with idle line must not disturb IDLE
    for (int i = 0; i < 20; i++) begin
      @(negedge clk) force_bps = 1'b1;
      @(negedge clk) force_bps = 1'b0;
      check("forced_bps_busy", {31'd0, rx_busy}, 32'd0);
      check("forced_bps_start", {31'd0, bps_start}, 32'd0);
      repeat (3) @(negedge clk);
    end

    // Reset during data bit 4
    rs232_rx = 1'b0;
    wait_bits(1);
    for (int i = 0; i < 4; i++) begin
      rs232_rx = i[0];
      wait_bits(1);
    end
    rs232_rx = 1'b1;
    repeat (BIT / 2) @(negedge clk);
    check("busy_before_rst", {31'd0, rx_busy}, 32'd1);
    check("bps_before_rst", {31'd0, bps_start}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("midrst_bps_start", {31'd0, bps_start}, 32'd0);
    check("midrst_rx_busy", {31'd0, rx_busy}, 32'd0);
    check("midrst_rx_data", {24'd0, rx_data}, 32'd0);
    check("midrst_strobes", {30'd0, rx_valid, frame_err}, 32'd0);
    last_good = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wait_bits(2);
    send_frame(8'h3C, 1'b1);
    rs232_rx = 1'b1;
    wait_bits(1);
    drain("drain_3c");

    // Random traffic with occasional bad stop bits and varied gaps
    for (int n = 0; n < 30; n++) begin
      logic [7:0]  d;
      bit          bad;
      int unsigned gap;
      d   = 8'($urandom_range(0, 255));
      bad = ($urandom_range(0, 7) == 0);
      gap = bad ? 1 + $urandom_range(0, 1) : $urandom_range(0, 2);
      send_frame(d, !bad);
      rs232_rx = 1'b1;
      if (gap != 0) wait_bits(gap);
    end
    rs232_rx = 1'b1;
    wait_bits(2);
    drain("drain_random");
    check("final_idle", {31'd0, rx_busy}, 32'd0);
    check("final_bps_low", {31'd0, bps_start}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
